// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, instruction classes and control FSM state encodings.
package cpu_defs;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_HALT,
    CLS_NOP
  } op_class_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Undefined opcodes fall into the nop class so they retire harmlessly after T3.
  function automatic op_class_e op_class(input logic [4:0] op);
    if (op <= OP_ROL)                      return CLS_ALU;
    else if (op == OP_MUL || op == OP_DIV) return CLS_MULDIV;
    else if (op == OP_HALT)                return CLS_HALT;
    else                                   return CLS_NOP;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Moore-decoded control FSM: fetch (T0-T2), class-dependent execute (T3-T6), HALT.
module control_unit
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZHIin,
  output logic        ZLOin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [4:0]  operation,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        run,
  output logic [3:0]  state
);

  state_e    state_q, state_d;
  op_class_e cls;
  logic [4:0] opcode;
  logic       unused_ir_fields;

  assign opcode           = ir[31:27];
  assign cls              = op_class(opcode);
  assign unused_ir_fields = ^ir[26:0];
  assign state            = state_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_RESET;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        unique case (cls)
          CLS_ALU, CLS_MULDIV: state_d = S_T4;
          CLS_HALT:            state_d = S_HALT;
          default:             state_d = S_T0;
        endcase
      end
      S_T4:    state_d = S_T5;
      S_T5:    state_d = (cls == CLS_MULDIV) ? S_T6 : S_T0;
      S_T6:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    ZHIin = 1'b0; ZLOin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    operation = '0;
    run = (state_q != S_RESET) && (state_q != S_HALT);
    unique case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (cls == CLS_ALU) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      S_T4: begin
        if (cls == CLS_ALU) begin
          Grc = 1'b1; Rout = 1'b1; operation = opcode; ZLOin = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          Grb = 1'b1; Rout = 1'b1; operation = opcode; ZHIin = 1'b1; ZLOin = 1'b1;
        end
      end
      S_T5: begin
        if (cls == CLS_ALU) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (cls == CLS_MULDIV) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end
      end
      S_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: instruction sequences, halt, and mid-instruction reset.
module tb_control_unit;
  import cpu_defs::*;

  logic        clk, clr;
  logic [31:0] ir;
  logic PCout, Zlowout, ZHighout, MDRout, HIout, LOout;
  logic MARin, PCin, MDRin, IRin, Yin, ZHIin, ZLOin, HIin, LOin, IncPC, Read;
  logic [4:0] operation;
  logic Gra, Grb, Grc, Rin, Rout, run;
  logic [3:0] state;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .ZHIin(ZHIin), .ZLOin(ZLOin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .operation(operation),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .run(run), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe vector bit positions, MSB first.
  localparam logic [22:0] B_PCOUT = 23'h1 << 22, B_ZLOWOUT = 23'h1 << 21, B_ZHIGHOUT = 23'h1 << 20;
  localparam logic [22:0] B_MDROUT = 23'h1 << 19, B_HIOUT = 23'h1 << 18, B_LOOUT = 23'h1 << 17;
  localparam logic [22:0] B_MARIN = 23'h1 << 16, B_PCIN = 23'h1 << 15, B_MDRIN = 23'h1 << 14;
  localparam logic [22:0] B_IRIN = 23'h1 << 13, B_YIN = 23'h1 << 12, B_ZHIIN = 23'h1 << 11;
  localparam logic [22:0] B_ZLOIN = 23'h1 << 10, B_HIIN = 23'h1 << 9, B_LOIN = 23'h1 << 8;
  localparam logic [22:0] B_INCPC = 23'h1 << 7, B_READ = 23'h1 << 6, B_GRA = 23'h1 << 5;
  localparam logic [22:0] B_GRB = 23'h1 << 4, B_GRC = 23'h1 << 3, B_RIN = 23'h1 << 2;
  localparam logic [22:0] B_ROUT = 23'h1 << 1, B_RUN = 23'h1;

  localparam logic [22:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLOIN | B_RUN;
  localparam logic [22:0] F_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [22:0] F_T2 = B_MDROUT | B_IRIN | B_RUN;

  localparam logic [31:0] IR_SHRA = 32'h2891_8000;
  localparam logic [31:0] IR_ADD  = 32'h0091_8000;
  localparam logic [31:0] IR_MUL  = 32'h7890_0000;
  localparam logic [31:0] IR_DIV  = 32'h8090_0000;
  localparam logic [31:0] IR_UND  = 32'hA800_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  st;
    logic [22:0] strb;
    logic [4:0]  op;
    string       name;
  } vec_t;

  localparam int NVEC = 34;
  vec_t tbl [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic logic [22:0] strobes();
    return {PCout, Zlowout, ZHighout, MDRout, HIout, LOout, MARin, PCin, MDRin,
            IRin, Yin, ZHIin, ZLOin, HIin, LOin, IncPC, Read, Gra, Grb, Grc,
            Rin, Rout, run};
  endfunction

  task automatic check(input string name, input logic [3:0] st,
                       input logic [22:0] strb, input logic [4:0] op);
    logic [22:0] got;
    got = strobes();
    checks++;
    if (state !== st || got !== strb || operation !== op) begin
      errors++;
      $display("FAIL %s: got state=%0d strobes=%h op=%b, expected state=%0d strobes=%h op=%b",
               name, state, got, operation, st, strb, op);
    end
  endtask

  // Bus-exclusivity and register-select one-hot, checked every cycle.
  always @(negedge clk) begin
    if (clr) begin
      checks++;
      if ($countones({PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Rout}) > 1 ||
          $countones({Gra, Grb, Grc}) > 1) begin
        errors++;
        $display("FAIL exclusivity: bus=%b sel=%b, expected at most one high in each",
                 {PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Rout}, {Gra, Grb, Grc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [31:0] i, input state_e s, input logic [22:0] b,
                              input logic [4:0] o, input string n);
    vec_t v;
    v.ir = i; v.st = s; v.strb = b; v.op = o; v.name = n;
    return v;
  endfunction

  initial begin
    // ir changes only in T2, as the datapath IR would load it.
    tbl[0]  = mk(32'h0,   S_T0, F_T0, 5'b0, "shra_T0");
    tbl[1]  = mk(32'h0,   S_T1, F_T1, 5'b0, "shra_T1");
    tbl[2]  = mk(IR_SHRA, S_T2, F_T2, 5'b0, "shra_T2");
    tbl[3]  = mk(IR_SHRA, S_T3, B_GRB | B_ROUT | B_YIN | B_RUN, 5'b0, "shra_T3");
    tbl[4]  = mk(IR_SHRA, S_T4, B_GRC | B_ROUT | B_ZLOIN | B_RUN, 5'b00101, "shra_T4");
    tbl[5]  = mk(IR_SHRA, S_T5, B_ZLOWOUT | B_GRA | B_RIN | B_RUN, 5'b0, "shra_T5");
    tbl[6]  = mk(IR_SHRA, S_T0, F_T0, 5'b0, "mul_T0");
    tbl[7]  = mk(IR_SHRA, S_T1, F_T1, 5'b0, "mul_T1");
    tbl[8]  = mk(IR_MUL,  S_T2, F_T2, 5'b0, "mul_T2");
    tbl[9]  = mk(IR_MUL,  S_T3, B_GRA | B_ROUT | B_YIN | B_RUN, 5'b0, "mul_T3");
    tbl[10] = mk(IR_MUL,  S_T4, B_GRB | B_ROUT | B_ZHIIN | B_ZLOIN | B_RUN, 5'b01111, "mul_T4");
    tbl[11] = mk(IR_MUL,  S_T5, B_ZLOWOUT | B_LOIN | B_RUN, 5'b0, "mul_T5");
    tbl[12] = mk(IR_MUL,  S_T6, B_ZHIGHOUT | B_HIIN | B_RUN, 5'b0, "mul_T6");
    tbl[13] = mk(IR_MUL,  S_T0, F_T0, 5'b0, "und_T0");
    tbl[14] = mk(IR_MUL,  S_T1, F_T1, 5'b0, "und_T1");
    tbl[15] = mk(IR_UND,  S_T2, F_T2, 5'b0, "und_T2");
    tbl[16] = mk(IR_UND,  S_T3, B_RUN, 5'b0, "und_T3");
    tbl[17] = mk(IR_UND,  S_T0, F_T0, 5'b0, "nop_T0");
    tbl[18] = mk(IR_UND,  S_T1, F_T1, 5'b0, "nop_T1");
    tbl[19] = mk(IR_NOP,  S_T2, F_T2, 5'b0, "nop_T2");
    tbl[20] = mk(IR_NOP,  S_T3, B_RUN, 5'b0, "nop_T3");
    tbl[21] = mk(IR_NOP,  S_T0, F_T0, 5'b0, "add_T0");
    tbl[22] = mk(IR_NOP,  S_T1, F_T1, 5'b0, "add_T1");
    tbl[23] = mk(IR_ADD,  S_T2, F_T2, 5'b0, "add_T2");
    tbl[24] = mk(IR_ADD,  S_T3, B_GRB | B_ROUT | B_YIN | B_RUN, 5'b0, "add_T3");
    tbl[25] = mk(IR_ADD,  S_T4, B_GRC | B_ROUT | B_ZLOIN | B_RUN, 5'b00000, "add_T4");
    tbl[26] = mk(IR_ADD,  S_T5, B_ZLOWOUT | B_GRA | B_RIN | B_RUN, 5'b0, "add_T5");
    tbl[27] = mk(IR_ADD,  S_T0, F_T0, 5'b0, "div_T0");
    tbl[28] = mk(IR_ADD,  S_T1, F_T1, 5'b0, "div_T1");
    tbl[29] = mk(IR_DIV,  S_T2, F_T2, 5'b0, "div_T2");
    tbl[30] = mk(IR_DIV,  S_T3, B_GRA | B_ROUT | B_YIN | B_RUN, 5'b0, "div_T3");
    tbl[31] = mk(IR_DIV,  S_T4, B_GRB | B_ROUT | B_ZHIIN | B_ZLOIN | B_RUN, 5'b10000, "div_T4");
    tbl[32] = mk(IR_DIV,  S_T5, B_ZLOWOUT | B_LOIN | B_RUN, 5'b0, "div_T5");
    tbl[33] = mk(IR_DIV,  S_T6, B_ZHIGHOUT | B_HIIN | B_RUN, 5'b0, "div_T6");

    clr = 1'b0;
    ir  = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_hold", S_RESET, '0, 5'b0);
    clr = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      ir = tbl[i].ir;
      @(negedge clk);
      check(tbl[i].name, tbl[i].st, tbl[i].strb, tbl[i].op);
    end

    // Halt: fetch, T3, then HALT held with everything low.
    @(negedge clk); check("halt_T0", S_T0, F_T0, 5'b0);
    @(negedge clk); check("halt_T1", S_T1, F_T1, 5'b0);
    ir = IR_HALT;
    @(negedge clk); check("halt_T2", S_T2, F_T2, 5'b0);
    @(negedge clk); check("halt_T3", S_T3, B_RUN, 5'b0);
    for (int c = 0; c < 21; c++) begin
      @(negedge clk); check("halt_hold", S_HALT, '0, 5'b0);
    end

    // Reset from HALT, then clr asserted mid-cycle during T4 of an add.
    clr = 1'b0;
    #1 check("halt_clr", S_RESET, '0, 5'b0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk); check("clr_T0", S_T0, F_T0, 5'b0);
    @(negedge clk); check("clr_T1", S_T1, F_T1, 5'b0);
    ir = IR_ADD;
    @(negedge clk); check("clr_T2", S_T2, F_T2, 5'b0);
    @(negedge clk); check("clr_T3", S_T3, B_GRB | B_ROUT | B_YIN | B_RUN, 5'b0);
    @(negedge clk); check("clr_T4", S_T4, B_GRC | B_ROUT | B_ZLOIN | B_RUN, 5'b0);
    #1 clr = 1'b0;
    #1 check("clr_async", S_RESET, '0, 5'b0);
    @(negedge clk); check("clr_held", S_RESET, '0, 5'b0);
    clr = 1'b1;
    @(negedge clk); check("restart_T0", S_T0, F_T0, 5'b0);
    @(negedge clk); check("restart_T1", S_T1, F_T1, 5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 clr  input  1  reset, asynchronous, active-low.
REQ-003 ir  input  32  instruction register contents; opcode = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
REQ-004 PCout, Zlowout, ZHighout, MDRout, HIout, LOout  output  1 each  datapath bus-drive enables.
REQ-005 MARin, PCin, MDRin, IRin, Yin, ZHIin, ZLOin, HIin, LOin, IncPC, Read  output  1 each  datapath load/control strobes.
REQ-006 operation  output  5  ALU opcode to datapath; 5'b00000 when no ALU op is active.
REQ-007 Gra, Grb, Grc  output  1 each  register-field select for the select/encode logic; at most one asserted per cycle.
REQ-008 Rin, Rout  output  1 each  load or drive of the selected general register.
REQ-009 run  output  1  high while executing; low in HALT.
REQ-010 state  output  4  current FSM state, for debug.

Function
REQ-011 The FSM SHALL implement these states: RESET, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-012 RESET SHALL advance to T0 on the first clock after clr deasserts.
REQ-013 In T0 the block SHALL assert PCout, MARin, IncPC and ZLOin.
REQ-014 In T1 the block SHALL assert Zlowout, PCin, Read and MDRin.
REQ-015 In T2 the block SHALL assert MDRout and IRin; ir is valid from T3 onward.
REQ-016 ALU class (opcode 00000 add … 01000 rol: add, sub, and, or, shr, shra, shl, ror, rol) SHALL execute three states, then return to T0:
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, operation = opcode, ZLOin.
- T5: Zlowout, Gra, Rin.
REQ-017 MULDIV class (01111 mul, 10000 div) SHALL execute four states, then return to T0:
- T3: Gra, Rout, Yin.
- T4: Grb, Rout, operation = opcode, ZHIin, ZLOin.
- T5: Zlowout, LOin.
- T6: ZHighout, HIin.
REQ-018 Opcode 11011 (halt) SHALL go from T3 to HALT; HALT SHALL hold with all strobes 0 and run = 0 until reset.
REQ-019 Opcode 11010 (nop) and every undefined opcode SHALL go from T3 to T0 with no strobes asserted in T3.
REQ-020 Outputs SHALL be Moore-decoded from the state register and ir, and SHALL be stable for the whole cycle.
REQ-021 No two bus-drive enables (PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Rout) SHALL be high in the same cycle.
REQ-022 Instruction latency SHALL be 6 cycles for the ALU class, 7 for MULDIV, and 4 for nop.

Reset
REQ-023 clr low SHALL immediately force state to RESET, all strobes to 0, operation to 0, and run to 0, including mid-instruction; no partial register write completes.
REQ-024 run SHALL become 1 in the first T0 after reset.

Structure
REQ-025 Opcode constants, class groupings and state encodings SHALL reside in a shared package, cpu_defs, reused by the datapath and benches.
REQ-026 The design SHALL be a single module with no sub-module; the register select/encode block stays external.

Verification
REQ-027 Reset then ir = 0x28918000 (shra, ra = R1, rb = R2, rc = R3) -> T0..T5 in 6 cycles; T3 Grb + Rout + Yin; T4 Grc + Rout + operation = 00101 + ZLOin; T5 Zlowout + Gra + Rin; next state T0.
REQ-028 ir opcode 01111 (mul) -> T5 Zlowout + LOin, T6 ZHighout + HIin, then T0; 7 cycles total.
REQ-029 ir opcode 11011 -> HALT after T3, run = 0, strobes 0 for 20 further cycles.
REQ-030 ir opcode 10101 (undefined) -> T3 all strobes 0, T0 on next cycle.
REQ-031 clr pulled low during T4 of an add -> state = RESET and all outputs 0 within the same cycle; fetch restarts at T0 one cycle after release.
REQ-032 Assertion over all scenarios: never more than one bus-drive enable high, and never more than one of Gra/Grb/Grc high.
